// File: rtl/ram_bus_ctrl_pkg.sv
// Shared types and sizing for the Attocore memory-side bus controller.
package attocore_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/ram_bus_ctrl_if.sv
// Core-side request/response channel of the RAM bus controller.
interface ram_bus_ctrl_if
    import attocore_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_wide;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_wide, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wide, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_bus_ctrl.sv
// Converts core byte/wide load-store requests into the synchronous RAM's
// cs/rw/bidirectional-data protocol, one byte per RAM access.
module ram_bus_ctrl
    import attocore_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clock,
    input  logic              reset,
    ram_bus_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_cs,
    output logic              ram_rw
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic                idx_r;
    logic                wide_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wr_byte_r;
    logic [DATA_W-1:0]   wdata_hi_r;
    logic [DATA_W-1:0]   lo_byte_r;

    // The bus is driven only during a write cycle, so the RAM never contends.
    assign ram_data = (ram_cs && ram_rw) ? wr_byte_r : {DATA_W{1'bz}};

    // Access sequencer: every output is registered and set one edge ahead.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= 1'b0;
            wide_r        <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            wr_byte_r     <= {DATA_W{1'b0}};
            wdata_hi_r    <= {DATA_W{1'b0}};
            lo_byte_r     <= {DATA_W{1'b0}};
            ram_address   <= {ADDR_W{1'b0}};
            ram_cs        <= 1'b0;
            ram_rw        <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= {(2*DATA_W){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_r       <= bus.req_we ? WR : RD_ADDR;
                        idx_r         <= 1'b0;
                        wide_r        <= bus.req_wide;
                        addr_r        <= bus.req_addr;
                        wr_byte_r     <= bus.req_wdata[DATA_W-1:0];
                        wdata_hi_r    <= bus.req_wdata[2*DATA_W-1:DATA_W];
                        ram_address   <= bus.req_addr;
                        ram_cs        <= 1'b1;
                        ram_rw        <= bus.req_we;
                        bus.req_ready <= 1'b0;
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                WR: begin
                    if (wide_r && !idx_r) begin
                        idx_r         <= 1'b1;
                        ram_address   <= addr_r + ADDR_ONE;
                        wr_byte_r     <= wdata_hi_r;
                    end else begin
                        state_r       <= RESP;
                        ram_cs        <= 1'b0;
                        ram_rw        <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    state_r <= RD_DATA;
                end
                RD_DATA: begin
                    // Low byte is parked until the high byte arrives so the
                    // visible load result only changes on completion.
                    if (wide_r && !idx_r) begin
                        lo_byte_r     <= ram_data;
                        idx_r         <= 1'b1;
                        ram_address   <= addr_r + ADDR_ONE;
                        state_r       <= RD_ADDR;
                    end else begin
                        state_r       <= RESP;
                        ram_cs        <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= wide_r ? {ram_data, lo_byte_r}
                                                : {{DATA_W{1'b0}}, ram_data};
                    end
                end
                RESP: begin
                    state_r       <= IDLE;
                    idx_r         <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state_r       <= IDLE;
                    idx_r         <= 1'b0;
                    ram_cs        <= 1'b0;
                    ram_rw        <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Self-checking bench for ram_bus_ctrl: directed table, random traffic
// against a byte-array memory model, and a mid-load reset.
module tb_ram_bus_ctrl;
    import attocore_mem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;
    logic          ram_cs;
    logic          ram_rw;

    ram_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_rw(ram_rw)
    );

    // 1024x8 synchronous RAM: registered read, drives only while selected for read.
    logic [DW-1:0] ram_mem [0:RAM_DEPTH-1];
    logic [DW-1:0] rd_q;
    logic          rd_en = 1'b0;
    always @(posedge clock) begin
        if (ram_cs && ram_rw) ram_mem[ram_address] <= ram_data;
        rd_en <= ram_cs && !ram_rw;
        rd_q  <= ram_mem[ram_address];
    end
    assign ram_data = (rd_en && ram_cs && !ram_rw) ? rd_q : 8'hzz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic is_load; logic [15:0] rdata; int acc; int lat; } exp_t;
    typedef struct { logic [9:0] addr; logic [7:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];
    exp_t mon_e;
    wr_t  mon_w;
    logic [7:0]  model_mem [0:RAM_DEPTH-1];
    logic [15:0] last_rdata = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int exp_lat(input logic we, input logic wide);
        if (we) return wide ? 3 : 2;
        return wide ? 5 : 3;
    endfunction

    function automatic logic [15:0] model_load(input logic wide, input logic [9:0] addr);
        logic [9:0] a1;
        a1 = addr + 10'd1;
        return wide ? {model_mem[a1], model_mem[addr]} : {8'h00, model_mem[addr]};
    endfunction

    // Response and write-cycle monitor against the bench's expectation queues.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
                    if (mon_e.is_load) last_rdata = mon_e.rdata;
                    check("rsp_rdata", {16'h0000, bus.rsp_rdata}, {16'h0000, last_rdata});
                end
            end
            if (ram_cs && ram_rw) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", {22'd0, ram_address}, {22'd0, mon_w.addr});
                    check("wr_data", {24'd0, ram_data}, {24'd0, mon_w.data});
                end
            end
        end
    end

    // Present a request (valid stays high on return) and record what must follow.
    task automatic issue(input logic we, input logic wide, input logic [9:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd, input bit expect_rsp);
        bit done = 1'b0;
        logic [9:0] a1;
        a1 = addr + 10'd1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_wide = wide;
        bus.req_addr = addr;  bus.req_wdata = wdata;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                done = 1'b1;
                if (expect_rsp) exp_q.push_back('{!we, exp_rd, cyc, exp_lat(we, wide)});
                if (we) begin
                    wr_q.push_back('{addr, wdata[7:0]});
                    model_mem[addr] = wdata[7:0];
                    if (wide) begin
                        wr_q.push_back('{a1, wdata[15:8]});
                        model_mem[a1] = wdata[15:8];
                    end
                end
            end
            @(posedge clock);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clock);
        #1;
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    typedef struct {
        logic we; logic wide; logic [9:0] addr; logic [15:0] wdata; logic [15:0] exp;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [9:0]  a;
        logic [15:0] d;
        logic        we;
        logic        wide;

        tbl[0] = '{1'b1, 1'b0, 10'h010, 16'h00A5, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 10'h010, 16'h0000, 16'h00A5};
        tbl[2] = '{1'b1, 1'b1, 10'h3FF, 16'hBEEF, 16'h0000};
        tbl[3] = '{1'b0, 1'b1, 10'h3FF, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b0, 10'h155, 16'h003C, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 10'h155, 16'h0000, 16'h003C};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_wide = 1'b0;
        bus.req_addr = 10'h000; bus.req_wdata = 16'h0000;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_ram_rw", {31'd0, ram_rw}, 32'd0);
        check("rst_ram_address", {22'd0, ram_address}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;

        // Directed table, issued back-to-back with req_valid held high.
        for (int i = 0; i < 6; i++)
            issue(tbl[i].we, tbl[i].wide, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
        drain();
        check("ram_3ff", {24'd0, ram_mem[10'h3FF]}, 32'h000000EF);
        check("ram_000", {24'd0, ram_mem[10'h000]}, 32'h000000BE);

        // Fill the random window 0x3F0..0x010 (wraps through 0x000).
        for (int i = 0; i < 33; i++) begin
            a = 10'h3F0 + i[9:0];
            d = 16'($urandom);
            issue(1'b1, 1'b0, a, d, 16'h0000, 1'b1);
        end
        drain();

        // Random loads/stores against the memory model, with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            wide = 1'($urandom_range(0, 1));
            a    = 10'h3F0 + 10'($urandom_range(0, 31));
            d    = 16'($urandom);
            issue(we, wide, a, d, model_load(wide, a), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1;
            end
        end
        drain();

        // Reset during the second RD_DATA of a wide load: no response, bus idle.
        issue(1'b0, 1'b1, 10'h3FF, 16'h0000, 16'h0000, 1'b0);
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        reset = 1'b0;
        last_rdata = 16'h0000;
        repeat (6) @(posedge clock);
        #1;

        // Recovery after the abort.
        issue(1'b0, 1'b1, 10'h00F, 16'h0000, model_load(1'b1, 10'h00F), 1'b1);
        issue(1'b1, 1'b1, 10'h3FF, 16'h1234, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 10'h3FF, 16'h0000, 16'h1234, 1'b1);
        drain();
        repeat (4) @(posedge clock);
        #1;
        check("final_exp_q", exp_q.size(), 32'd0);
        check("final_wr_q", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_ctrl.md
# ram_bus_ctrl

Memory-side bus controller for the Attocore datapath. It sits directly upstream of the 1024×8 synchronous RAM and converts single-cycle core load/store requests, including 16-bit little-endian "wide" accesses, into the RAM's cs/rw/bidirectional-data protocol. It owns all bus turnaround and the two-cycle read capture, and returns each completed access to the core as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 10, RAM address width; wraps modulo 2^ADDR_W.
- DATA_W, 8, RAM byte width; wide accesses are 2×DATA_W.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_wide  in  1  1 = 16-bit access (addr, addr+1), 0 = byte.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  2*DATA_W  store data; [7:0] goes to addr, [15:8] goes to addr+1.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  2*DATA_W  load result; held until the next load completes.
- ram_address  out  ADDR_W  RAM address, registered.
- ram_data  inout  DATA_W  RAM data bus; driven only when ram_cs && ram_rw, else high-Z.
- ram_cs  out  1  RAM chip select, registered.
- ram_rw  out  1  1 = write, 0 = read, registered.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, RESP. Byte index counter `idx` (0/1).
- IDLE: req_ready=1. On req_valid: latch we/wide/addr/wdata, clear idx, go to WR (store) or RD_ADDR (load).
- WR: ram_cs=1, ram_rw=1, ram_address=addr+idx, ram_data=wdata byte idx. If wide and idx=0, set idx=1 and stay in WR. Otherwise go to RESP.
- RD_ADDR: ram_cs=1, ram_rw=0, address presented. The RAM registers the byte at the end of this cycle. Go to RD_DATA.
- RD_DATA: cs/rw/address held. The RAM drives ram_data; the controller captures it into byte idx of rsp_rdata at the end of the cycle. If wide and idx=0, set idx=1 and go to RD_ADDR. Otherwise go to RESP.
- RESP: rsp_valid=1, ram_cs=0, then go to IDLE.
- Narrow load: rsp_rdata[15:8] is cleared to 0. Stores leave rsp_rdata unchanged.
- Address arithmetic is ADDR_W bits and wraps: 1023+1 → 0.
- req_valid outside IDLE is ignored (not queued). The core must hold the request until it sees req_ready.
- The controller never drives ram_data while ram_rw=0, so there is no bus contention by construction.

## Timing
Let c be the cycle in which the request is accepted.
- Byte store: WR at c+1, RESP at c+2, ready at c+3.
- Wide store: WR at c+1 and c+2, RESP at c+3.
- Byte load: RD_ADDR c+1, RD_DATA c+2, RESP c+3 with rdata valid.
- Wide load: c+1..c+4 for the two byte reads, RESP at c+5.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_cs=0, ram_rw=0, ram_address=0, ram_data high-Z, idx=0.
- Reset mid-operation: state returns to IDLE at the next edge and cs drops.
  - A write byte whose WR cycle coincides with reset is still committed by the RAM (the RAM has no reset).
  - No rsp_valid is issued for the aborted request.

## Structure
- Package attocore_mem_pkg holds:
  - state enum (IDLE, WR, RD_ADDR, RD_DATA, RESP);
  - ADDR_W/DATA_W defaults;
  - RAM_DEPTH=1024.
- Single module, no sub-modules. The FSM, idx counter and tristate assign are inline.

## Test plan
- Byte store 0xA5 @0x010, then byte load @0x010 → rsp_rdata=0x00A5, rsp_valid exactly at c+3 of the load.
- Wide store 0xBEEF @0x3FF → RAM[0x3FF]=0xEF, RAM[0x000]=0xBE. Wide load @0x3FF → 0xBEEF at c+5.
- Back-to-back requests with req_valid held high → each accepted only in IDLE. Exactly one rsp_valid per request, with no extra or lost accesses.
- Bus monitor across all scenarios → ram_data never X/contention, and driven by the controller only when cs=1 and rw=1.
- Reset asserted during RD_DATA of a wide load → no rsp_valid, cs=0 next cycle, req_ready=1, rsp_rdata=0.
- Stores interleaved with loads to the same address (0x155 ← 0x3C, load) → load returns the newly written 0x3C.
